// File: rtl/alu_result_checker_if.sv
// Transaction bus between the stimulus driver and the ALU result checker:
// applied operands/opcode plus the ALU's observed result and flags.
interface alu_result_checker_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       opc;
  logic [WIDTH-1:0] dut_w;
  logic             dut_z;
  logic             dut_n;

  modport master (
    output in_valid, a, b, cin, opc, dut_w, dut_z, dut_n,
    input  in_ready
  );

  modport slave (
    input  in_valid, a, b, cin, opc, dut_w, dut_z, dut_n,
    output in_ready
  );
endinterface

// File: rtl/alu_result_checker.sv
// Response-side scoreboard for the 16-bit ALU: recomputes each result with a
// golden model, counts pass/fail, captures the first failure, optionally halts.
module alu_result_checker #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned CNT_W        = 16,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_result_checker_if.slave  bus,
  input  logic                 clear,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count,
  output logic                 err_pulse,
  output logic                 halted,
  output logic                 ff_valid,
  output logic [2:0]           ff_opc,
  output logic [WIDTH+1:0]     ff_exp,
  output logic [WIDTH+1:0]     ff_got
);

  localparam int unsigned RES_W = WIDTH + 2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [2:0]       opc;
    logic [RES_W-1:0] got;
  } xact_t;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             s1_valid_q, s1_valid_d;
  xact_t            s1_q, s1_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [2:0]       ff_opc_q, ff_opc_d;
  logic [RES_W-1:0] ff_exp_q, ff_exp_d, ff_got_q, ff_got_d;

  logic             accept_c;
  logic             mismatch_c;
  logic [WIDTH-1:0] exp_w_c;
  logic [RES_W-1:0] exp_c;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state: halt on a stage-2 mismatch, leave only through clear
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = RUN;
    end else if (state_q == RUN && mismatch_c && STOP_ON_FAIL) begin
      state_d = HALT;
    end
  end

  // FSM outputs
  always_comb begin
    bus.in_ready = (state_q == RUN) & ~clear;
    halted       = (state_q == HALT);
  end

  // Golden model evaluated on the stage-1 snapshot
  always_comb begin
    exp_w_c = '0;
    case (s1_q.opc)
      3'd0:    exp_w_c = s1_q.a + s1_q.b + WIDTH'(s1_q.cin);
      3'd1:    exp_w_c = s1_q.a - s1_q.b - WIDTH'(s1_q.cin);
      3'd2:    exp_w_c = s1_q.a & s1_q.b;
      3'd3:    exp_w_c = s1_q.a | s1_q.b;
      3'd4:    exp_w_c = s1_q.a ^ s1_q.b;
      3'd5:    exp_w_c = ~s1_q.a;
      3'd6:    exp_w_c = {s1_q.a[WIDTH-2:0], s1_q.cin};
      default: exp_w_c = s1_q.b;
    endcase
    exp_c      = {exp_w_c, (exp_w_c == '0), exp_w_c[WIDTH-1]};
    mismatch_c = s1_valid_q & (exp_c != s1_q.got);
    accept_c   = bus.in_valid & bus.in_ready;
  end

  // Datapath next state: intake, compare, saturating counters, first-fail capture
  always_comb begin
    s1_valid_d = accept_c;
    s1_d       = s1_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_d      = 1'b0;
    ffv_d      = ffv_q;
    ff_opc_d   = ff_opc_q;
    ff_exp_d   = ff_exp_q;
    ff_got_d   = ff_got_q;

    if (accept_c) begin
      s1_d = '{a: bus.a, b: bus.b, cin: bus.cin, opc: bus.opc,
               got: {bus.dut_w, bus.dut_z, bus.dut_n}};
    end

    if (s1_valid_q) begin
      if (!mismatch_c) begin
        if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
      end else begin
        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
        err_d = 1'b1;
        if (!ffv_q) begin
          ffv_d    = 1'b1;
          ff_opc_d = s1_q.opc;
          ff_exp_d = exp_c;
          ff_got_d = s1_q.got;
        end
      end
    end

    if (clear) begin
      s1_valid_d = 1'b0;
      pass_d     = '0;
      fail_d     = '0;
      err_d      = 1'b0;
      ffv_d      = 1'b0;
      ff_opc_d   = '0;
      ff_exp_d   = '0;
      ff_got_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      err_q      <= 1'b0;
      ffv_q      <= 1'b0;
      ff_opc_q   <= '0;
      ff_exp_q   <= '0;
      ff_got_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      ffv_q      <= ffv_d;
      ff_opc_q   <= ff_opc_d;
      ff_exp_q   <= ff_exp_d;
      ff_got_q   <= ff_got_d;
    end
  end

  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign err_pulse  = err_q;
  assign ff_valid   = ffv_q;
  assign ff_opc     = ff_opc_q;
  assign ff_exp     = ff_exp_q;
  assign ff_got     = ff_got_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed + randomized bench for alu_result_checker: one halting 16-bit-counter
// instance and one non-halting 4-bit-counter instance for saturation.
module tb_alu_result_checker;

  logic clk;
  logic rst;
  logic clear0, clear1;

  logic [15:0] pass0, fail0;
  logic        err0, halted0, ffv0;
  logic [2:0]  ffopc0;
  logic [17:0] ffexp0, ffgot0;

  logic [3:0]  pass1, fail1;
  logic        err1, halted1, ffv1;
  logic [2:0]  ffopc1;
  logic [17:0] ffexp1, ffgot1;

  int checks;
  int failures;

  logic [15:0] ra, rb;
  logic        rc;
  logic [2:0]  ro;
  logic [17:0] e, first_exp, first_got;
  logic [2:0]  first_opc;

  alu_result_checker_if #(.WIDTH(16)) bus0 ();
  alu_result_checker_if #(.WIDTH(16)) bus1 ();

  alu_result_checker #(.WIDTH(16), .CNT_W(16), .STOP_ON_FAIL(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .clear(clear0),
    .pass_count(pass0), .fail_count(fail0), .err_pulse(err0), .halted(halted0),
    .ff_valid(ffv0), .ff_opc(ffopc0), .ff_exp(ffexp0), .ff_got(ffgot0)
  );

  alu_result_checker #(.WIDTH(16), .CNT_W(4), .STOP_ON_FAIL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .clear(clear1),
    .pass_count(pass1), .fail_count(fail1), .err_pulse(err1), .halted(halted1),
    .ff_valid(ffv1), .ff_opc(ffopc1), .ff_exp(ffexp1), .ff_got(ffgot1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: plain integer arithmetic reduced modulo 2^16
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic [2:0] opc);
    int unsigned ua, ub, c, r;
    ua = 32'(a);
    ub = 32'(b);
    c  = 32'(cin);
    case (opc)
      3'd0:    r = ua + ub + c;
      3'd1:    r = ua - ub - c;
      3'd2:    r = ua & ub;
      3'd3:    r = ua | ub;
      3'd4:    r = ua ^ ub;
      3'd5:    r = ~ua;
      3'd6:    r = ua * 32'd2 + c;
      default: r = ub;
    endcase
    r = r % 32'd65536;
    return {16'(r), (r == 32'd0), (r >= 32'd32768)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [2:0] opc, input logic [17:0] got);
    bus0.in_valid = v;
    bus0.a        = a;
    bus0.b        = b;
    bus0.cin      = cin;
    bus0.opc      = opc;
    bus0.dut_w    = got[17:2];
    bus0.dut_z    = got[1];
    bus0.dut_n    = got[0];
  endtask

  task automatic drive1(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [2:0] opc, input logic [17:0] got);
    bus1.in_valid = v;
    bus1.a        = a;
    bus1.b        = b;
    bus1.cin      = cin;
    bus1.opc      = opc;
    bus1.dut_w    = got[17:2];
    bus1.dut_z    = got[1];
    bus1.dut_n    = got[0];
  endtask

  task automatic new_tuple();
    ra = 16'($urandom);
    rb = 16'($urandom);
    rc = 1'($urandom);
    ro = 3'($urandom);
    e  = model(ra, rb, rc, ro);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear0   = 1'b0;
    clear1   = 1'b0;
    drive0(1'b0, '0, '0, 1'b0, 3'd0, '0);
    drive1(1'b0, '0, '0, 1'b0, 3'd0, '0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_in_ready", 64'(bus0.in_ready), 64'd1);
    check("rst_pass", 64'(pass0), 64'd0);
    check("rst_fail", 64'(fail0), 64'd0);
    check("rst_err", 64'(err0), 64'd0);
    check("rst_halted", 64'(halted0), 64'd0);
    check("rst_ffv", 64'(ffv0), 64'd0);
    check("rst_ffexp", 64'(ffexp0), 64'd0);

    // ADD with carry-out wrap
    drive0(1'b1, 16'hFFFF, 16'h0001, 1'b0, 3'd0, {16'h0000, 1'b1, 1'b0});
    tick();
    drive0(1'b0, '0, '0, 1'b0, 3'd0, '0);
    check("add_pass_1edge", 64'(pass0), 64'd0);
    tick();
    check("add_pass", 64'(pass0), 64'd1);
    check("add_err", 64'(err0), 64'd0);

    // SUB with borrow: matching, then n flag wrong
    drive0(1'b1, 16'h0000, 16'h0000, 1'b1, 3'd1, {16'hFFFF, 1'b0, 1'b1});
    tick();
    drive0(1'b0, '0, '0, 1'b0, 3'd0, '0);
    tick();
    check("sub_pass", 64'(pass0), 64'd2);
    drive0(1'b1, 16'h0000, 16'h0000, 1'b1, 3'd1, {16'hFFFF, 1'b0, 1'b0});
    tick();
    drive0(1'b0, '0, '0, 1'b0, 3'd0, '0);
    tick();
    check("sub_fail", 64'(fail0), 64'd1);
    check("sub_err", 64'(err0), 64'd1);
    check("sub_ffv", 64'(ffv0), 64'd1);
    check("sub_ffopc", 64'(ffopc0), 64'd1);
    check("sub_ffexp", 64'(ffexp0), 64'h3FFFD);
    check("sub_ffgot", 64'(ffgot0), 64'h3FFFC);
    check("sub_halted", 64'(halted0), 64'd1);
    tick();
    check("sub_err_pulse_end", 64'(err0), 64'd0);

    // Clear out of HALT
    clear0 = 1'b1;
    #1;
    check("clr_in_ready_low", 64'(bus0.in_ready), 64'd0);
    tick();
    clear0 = 1'b0;
    #1;
    check("clr_pass", 64'(pass0), 64'd0);
    check("clr_fail", 64'(fail0), 64'd0);
    check("clr_ffv", 64'(ffv0), 64'd0);
    check("clr_halted", 64'(halted0), 64'd0);
    check("clr_in_ready", 64'(bus0.in_ready), 64'd1);

    // Halt under continuous traffic: mismatch, then correct tuples every cycle
    new_tuple();
    drive0(1'b1, ra, rb, rc, ro, e ^ 18'h00004);
    tick();
    new_tuple();
    drive0(1'b1, ra, rb, rc, ro, e);
    check("halt_not_yet", 64'(halted0), 64'd0);
    tick();
    check("halt_halted", 64'(halted0), 64'd1);
    check("halt_in_ready", 64'(bus0.in_ready), 64'd0);
    check("halt_fail", 64'(fail0), 64'd1);
    new_tuple();
    drive0(1'b1, ra, rb, rc, ro, e);
    tick();
    check("halt_inflight_pass", 64'(pass0), 64'd1);
    tick();
    tick();
    check("halt_pass_frozen", 64'(pass0), 64'd1);
    check("halt_fail_frozen", 64'(fail0), 64'd1);

    // clear with in_valid still high: clear wins, transaction dropped
    clear0 = 1'b1;
    tick();
    clear0 = 1'b0;
    drive0(1'b0, '0, '0, 1'b0, 3'd0, '0);
    #1;
    check("clr2_in_ready", 64'(bus0.in_ready), 64'd1);
    check("clr2_ffv", 64'(ffv0), 64'd0);
    tick();
    tick();
    check("clr2_no_accept", 64'(pass0), 64'd0);

    // Back-to-back stream of 1000 correct tuples
    for (int i = 0; i < 1000; i++) begin
      new_tuple();
      drive0(1'b1, ra, rb, rc, ro, e);
      tick();
      check("stream_in_ready", 64'(bus0.in_ready), 64'd1);
    end
    drive0(1'b0, '0, '0, 1'b0, 3'd0, '0);
    tick();
    tick();
    check("stream_pass", 64'(pass0), 64'd1000);
    check("stream_fail", 64'(fail0), 64'd0);

    // Saturation on the 4-bit, non-halting instance
    for (int i = 0; i < 20; i++) begin
      new_tuple();
      if (i == 0) begin
        first_exp = e;
        first_got = e ^ (18'd1 << $urandom_range(0, 17));
        first_opc = ro;
        drive1(1'b1, ra, rb, rc, ro, first_got);
      end else begin
        drive1(1'b1, ra, rb, rc, ro, e ^ (18'd1 << $urandom_range(0, 17)));
      end
      tick();
      check("sat_in_ready", 64'(bus1.in_ready), 64'd1);
    end
    drive1(1'b0, '0, '0, 1'b0, 3'd0, '0);
    tick();
    tick();
    check("sat_fail", 64'(fail1), 64'hF);
    check("sat_pass", 64'(pass1), 64'd0);
    check("sat_halted", 64'(halted1), 64'd0);
    check("sat_ffopc", 64'(ffopc1), 64'(first_opc));
    check("sat_ffexp", 64'(ffexp1), 64'(first_exp));
    check("sat_ffgot", 64'(ffgot1), 64'(first_got));

    // Reset one cycle after accepting a mismatching transaction
    new_tuple();
    drive0(1'b1, ra, rb, rc, ro, e ^ 18'h00001);
    tick();
    drive0(1'b0, '0, '0, 1'b0, 3'd0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_fail", 64'(fail0), 64'd0);
    check("rstmid_pass", 64'(pass0), 64'd0);
    check("rstmid_err", 64'(err0), 64'd0);
    check("rstmid_ffv", 64'(ffv0), 64'd0);
    check("rstmid_fail1", 64'(fail1), 64'd0);
    tick();
    tick();
    check("rstmid_dropped_fail", 64'(fail0), 64'd0);
    check("rstmid_dropped_err", 64'(err0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Response-side scoreboard for the 16-bit ALU: consumes each applied operand/opcode tuple together with the ALU's observed result and flags, and recomputes the expected result with an internal golden model.
- Counts passes and fails, captures the first failing transaction, and can halt intake on the first failure.
- Sits downstream of the stimulus driver and the ALU, in both simulation benches and on-board self-test.

Parameters:
- WIDTH, 16, operand/result width.
- CNT_W, 16, width of pass/fail counters; counters saturate at all-ones.
- STOP_ON_FAIL, 1, when 1, intake halts after the first mismatch until clear.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  transaction present on a/b/cin/opc/dut_*.
- in_ready  out  1  checker accepts the transaction this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- opc  in  3  opcode.
- dut_w  in  WIDTH  ALU result.
- dut_z  in  1  ALU zero flag.
- dut_n  in  1  ALU negative flag.
- clear  in  1  synchronous clear of counters, capture registers and halt state.
- pass_count  out  CNT_W  matching transactions.
- fail_count  out  CNT_W  mismatching transactions.
- err_pulse  out  1  one-cycle pulse per mismatch.
- halted  out  1  intake stopped after a failure.
- ff_valid  out  1  first-fail capture holds data.
- ff_opc  out  3  opcode of the first failure.
- ff_exp  out  WIDTH+2  expected {w,z,n} of the first failure.
- ff_got  out  WIDTH+2  observed {w,z,n} of the first failure.

Behaviour:
- Reset values: all outputs 0, except in_ready, which is 1 in the first cycle after reset deasserts. FSM is in RUN. Any in-flight transaction is dropped.
- Accept rule: a transaction is accepted when in_valid & in_ready on a rising edge.
- in_ready = (state==RUN) & ~clear.
- Golden model, w truncated to WIDTH:
  - 0: a+b+cin
  - 1: a-b-cin
  - 2: a&b
  - 3: a|b
  - 4: a^b
  - 5: ~a
  - 6: {a[WIDTH-2:0],cin}
  - 7: b
- Expected flags: z = (w==0), n = w[WIDTH-1].
- Pipeline:
  - Stage 1 (accept edge) registers {a,b,cin,opc,dut_*}.
  - Stage 2 (next edge) computes expected, compares all WIDTH+2 bits, and updates counters, err_pulse and first-fail.
  - Counter/err_pulse update is visible 2 edges after accept. Throughput is 1 transaction per cycle.
- Counters: pass_count++ on match, fail_count++ on mismatch. Both saturate and do not wrap.
- First-fail capture: loads only when ff_valid==0. It is sticky until clear or rst.
- FSM states:
  - RUN: accepting. On a stage-2 mismatch with STOP_ON_FAIL=1, go to HALT. A transaction accepted in the same cycle that the mismatch is detected is still completed and counted.
  - HALT: in_ready=0, halted=1. Leaves HALT only via clear or rst.
  - With STOP_ON_FAIL=0, the FSM never leaves RUN.
- clear:
  - Synchronous. Zeroes counters, ff_* and err_pulse, discards both pipeline stages, and sets the FSM to RUN.
  - clear together with in_valid: clear wins and the transaction is not accepted (in_ready=0).
- rst dominates clear.

Test Plan:
- ADD: opc=0, a=16'hFFFF, b=16'h0001, cin=0, dut {0000,1,0} → pass_count=1 two edges after accept, err_pulse stays 0.
- SUB borrow: opc=1, a=16'h0000, b=16'h0000, cin=1, dut {FFFF,0,1} → pass. Then the same tuple with dut_n=0 → fail_count=1, err_pulse one cycle, ff_exp=18'h3FFFD, ff_got=18'h3FFFC, ff_opc=1.
- Halt: STOP_ON_FAIL=1, a mismatch followed by continuous valid traffic → halted=1 and in_ready=0 from the edge after detection. The transaction accepted during the detect cycle is counted. Assert clear → counters=0, ff_valid=0, in_ready=1 next cycle.
- Back-to-back stream: 1000 random tuples with correct dut_* driven every cycle → pass_count=1000, fail_count=0, in_ready never drops.
- Saturation: CNT_W=4, 20 mismatches with STOP_ON_FAIL=0 → fail_count holds 4'hF, ff_* hold the first failure only.
- Reset mid-stream: rst asserted one cycle after an accept whose dut data mismatches → no count, no err_pulse, all outputs 0 after the reset edge.
